// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg
//   Encodings shared by the bus-matrix input and output stages: AHB transfer
//   types, the INCR burst code used when a held SEQ is replayed, response
//   codes and the input-stage FSM state constants.
package ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Input-stage FSM states, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_mtx_addr_hold.sv
// ahb_mtx_addr_hold
//   One-entry address-phase register for the input stage. Loads the live
//   master address phase when capture is high and presents it back.
//   Ports:
//     HCLK, HRESET        clock, synchronous active-high reset
//     capture             load the *_i fields this cycle
//     *_i                 live master address-phase fields
//     *_o                 held address phase, as presented to the matrix
module ahb_mtx_addr_hold
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              capture,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        trans_i,
  input  logic              write_i,
  input  logic [2:0]        size_i,
  input  logic [2:0]        burst_i,
  input  logic [3:0]        prot_i,
  input  logic              lock_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        trans_o,
  output logic              write_o,
  output logic [2:0]        size_o,
  output logic [2:0]        burst_o,
  output logic [3:0]        prot_o,
  output logic              lock_o
);

  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [1:0]        trans_q, trans_d;
  logic              write_q, write_d;
  logic [2:0]        size_q,  size_d;
  logic [2:0]        burst_q, burst_d;
  logic [3:0]        prot_q,  prot_d;
  logic              lock_q,  lock_d;

  always_comb begin
    addr_d  = addr_q;
    trans_d = trans_q;
    write_d = write_q;
    size_d  = size_q;
    burst_d = burst_q;
    prot_d  = prot_q;
    lock_d  = lock_q;
    if (capture) begin
      addr_d  = addr_i;
      trans_d = trans_i;
      write_d = write_i;
      size_d  = size_i;
      burst_d = burst_i;
      prot_d  = prot_i;
      lock_d  = lock_i;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= '0;
      trans_q <= HTRANS_IDLE;
      write_q <= 1'b0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      trans_q <= trans_d;
      write_q <= write_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      prot_q  <= prot_d;
      lock_q  <= lock_d;
    end
  end

  // A held SEQ may reach a slave that never saw the earlier beats of its
  // burst (the grant can move between beats), so it is replayed as the
  // start of an undefined-length INCR burst.
  logic held_seq;
  assign held_seq = (trans_q == HTRANS_SEQ);

  assign addr_o  = addr_q;
  assign trans_o = held_seq ? HTRANS_NONSEQ : trans_q;
  assign write_o = write_q;
  assign size_o  = size_q;
  assign burst_o = held_seq ? HBURST_INCR : burst_q;
  assign prot_o  = prot_q;
  assign lock_o  = lock_q;

endmodule

// File: rtl/ahb_mtx_in_stage.sv
// ahb_mtx_in_stage
//   Bus-matrix input stage for one AHB master port. Forwards address phases
//   straight through when the output stage grants this port, otherwise holds
//   one phase and stalls the master until the grant arrives. Routes the
//   selected slave's HREADY/HRESP back during the owned data phase.
//   Ports:
//     HCLK, HRESET           clock, synchronous active-high reset
//     HSELS..HMASTLOCKS      master address phase, HREADYS bus-level ready
//     HREADYOUTS, HRESPS     ready/response returned to the master
//     req_port               request to the output-stage arbiter
//     HADDRM..HMASTLOCKM     address phase presented to the output stage
//     active_ob              output stage currently selects this port
//     HREADYM, HRESPM        ready/response from the selected slave
//
//   state | meaning
//   IDLE  | no held phase, no owned data phase; master sees ready/OKAY
//   PEND  | held address phase waiting for grant; master stalled
//   DATA  | data phase in progress through the output stage
module ahb_mtx_in_stage
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              req_port,
  output logic [ADDR_W-1:0] HADDRM,
  output logic [1:0]        HTRANSM,
  output logic              HWRITEM,
  output logic [2:0]        HSIZEM,
  output logic [2:0]        HBURSTM,
  output logic [3:0]        HPROTM,
  output logic              HMASTLOCKM,
  input  logic              active_ob,
  input  logic              HREADYM,
  input  logic              HRESPM
);

  logic [1:0] state_q, state_d;
  logic       vld;
  logic       addr_free;
  logic       direct_ok;
  logic       capture;
  logic       pend;

  logic [ADDR_W-1:0] hold_addr;
  logic [1:0]        hold_trans;
  logic              hold_write;
  logic [2:0]        hold_size;
  logic [2:0]        hold_burst;
  logic [3:0]        hold_prot;
  logic              hold_lock;

  assign vld       = HSELS & HREADYS & trans_active(HTRANSS);
  // A new address phase can be taken when nothing is held and no data
  // phase is still waiting on the slave.
  assign addr_free = (state_q == ST_IDLE) | ((state_q == ST_DATA) & HREADYM);
  assign direct_ok = active_ob & HREADYM;
  assign capture   = addr_free & vld & ~direct_ok;
  assign pend      = (state_q == ST_PEND);

  always_comb begin
    state_d = state_q;
    if (pend) begin
      if (direct_ok) state_d = ST_DATA;
    end else if (addr_free) begin
      if (vld) state_d = direct_ok ? ST_DATA : ST_PEND;
      else     state_d = ST_IDLE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  ahb_mtx_addr_hold #(
    .ADDR_W (ADDR_W)
  ) u_addr_hold (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .capture (capture),
    .addr_i  (HADDRS),
    .trans_i (HTRANSS),
    .write_i (HWRITES),
    .size_i  (HSIZES),
    .burst_i (HBURSTS),
    .prot_i  (HPROTS),
    .lock_i  (HMASTLOCKS),
    .addr_o  (hold_addr),
    .trans_o (hold_trans),
    .write_o (hold_write),
    .size_o  (hold_size),
    .burst_o (hold_burst),
    .prot_o  (hold_prot),
    .lock_o  (hold_lock)
  );

  // Depends on master inputs and state only, never on HREADYOUTS.
  assign req_port = pend | vld;

  always_comb begin
    HADDRM     = HADDRS;
    HTRANSM    = HTRANSS;
    HWRITEM    = HWRITES;
    HSIZEM     = HSIZES;
    HBURSTM    = HBURSTS;
    HPROTM     = HPROTS;
    HMASTLOCKM = HMASTLOCKS;
    if (pend) begin
      HADDRM     = hold_addr;
      HTRANSM    = hold_trans;
      HWRITEM    = hold_write;
      HSIZEM     = hold_size;
      HBURSTM    = hold_burst;
      HPROTM     = hold_prot;
      HMASTLOCKM = hold_lock;
    end
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    case (state_q)
      ST_PEND: begin
        HREADYOUTS = 1'b0;
        HRESPS     = HRESP_OKAY;
      end
      ST_DATA: begin
        HREADYOUTS = HREADYM;
        HRESPS     = HRESPM;
      end
      default: begin
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
module tb_ahb_mtx_in_stage;
  import ahb_mtx_pkg::*;

  logic        HCLK;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        req_port;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic        HWRITEM;
  logic [2:0]  HSIZEM;
  logic [2:0]  HBURSTM;
  logic [3:0]  HPROTM;
  logic        HMASTLOCKM;
  logic        active_ob;
  logic        HREADYM;
  logic        HRESPM;

  ahb_mtx_in_stage #(.ADDR_W(32)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSELS      (HSELS),
    .HADDRS     (HADDRS),
    .HTRANSS    (HTRANSS),
    .HWRITES    (HWRITES),
    .HSIZES     (HSIZES),
    .HBURSTS    (HBURSTS),
    .HPROTS     (HPROTS),
    .HMASTLOCKS (HMASTLOCKS),
    .HREADYS    (HREADYS),
    .HREADYOUTS (HREADYOUTS),
    .HRESPS     (HRESPS),
    .req_port   (req_port),
    .HADDRM     (HADDRM),
    .HTRANSM    (HTRANSM),
    .HWRITEM    (HWRITEM),
    .HSIZEM     (HSIZEM),
    .HBURSTM    (HBURSTM),
    .HPROTM     (HPROTM),
    .HMASTLOCKM (HMASTLOCKM),
    .active_ob  (active_ob),
    .HREADYM    (HREADYM),
    .HRESPM     (HRESPM)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the port is either free, waiting with one stored
  // phase, or owns a data phase at a slave.
  typedef enum {M_FREE, M_WAITING, M_OWNING} mode_t;
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } phase_t;

  mode_t  mode = M_FREE;
  phase_t stored[$];

  function automatic phase_t live_phase();
    phase_t p;
    p.addr = HADDRS; p.trans = HTRANSS; p.write = HWRITES; p.size = HSIZES;
    p.burst = HBURSTS; p.prot = HPROTS; p.lock = HMASTLOCKS;
    return p;
  endfunction

  function automatic logic master_valid();
    return HSELS && HREADYS && (HTRANSS == HTRANS_NONSEQ || HTRANSS == HTRANS_SEQ);
  endfunction

  task automatic model_check();
    phase_t e;
    logic   e_rdy, e_resp;
    if (mode == M_WAITING && stored.size() == 1) begin
      e = stored[0];
      // A replayed SEQ becomes the first beat of an INCR burst.
      if (e.trans == HTRANS_SEQ) begin
        e.trans = HTRANS_NONSEQ;
        e.burst = HBURST_INCR;
      end
    end else begin
      e = live_phase();
    end
    e_rdy  = (mode == M_WAITING) ? 1'b0 : (mode == M_OWNING) ? HREADYM : 1'b1;
    e_resp = (mode == M_OWNING) ? HRESPM : HRESP_OKAY;
    chk_eq("haddrm",  64'(HADDRM),     64'(e.addr));
    chk_eq("htransm", 64'(HTRANSM),    64'(e.trans));
    chk_eq("hwritem", 64'(HWRITEM),    64'(e.write));
    chk_eq("hsizem",  64'(HSIZEM),     64'(e.size));
    chk_eq("hburstm", 64'(HBURSTM),    64'(e.burst));
    chk_eq("hprotm",  64'(HPROTM),     64'(e.prot));
    chk_eq("hlockm",  64'(HMASTLOCKM), 64'(e.lock));
    chk_eq("hreadyouts", 64'(HREADYOUTS), 64'(e_rdy));
    chk_eq("hresps",  64'(HRESPS),     64'(e_resp));
    chk_eq("req_port", 64'(req_port),  64'((mode == M_WAITING) || master_valid()));
  endtask

  task automatic model_update();
    bit accept_new;
    if (HRESET) begin
      mode = M_FREE;
      stored.delete();
      return;
    end
    if (mode == M_WAITING) begin
      if (active_ob && HREADYM) begin
        stored.delete();
        mode = M_OWNING;
      end
      return;
    end
    accept_new = (mode == M_FREE) || HREADYM;
    if (!accept_new) return;
    if (!master_valid()) mode = M_FREE;
    else if (active_ob && HREADYM) mode = M_OWNING;
    else begin
      stored.delete();
      stored.push_back(live_phase());
      mode = M_WAITING;
    end
  endtask

  // Inputs are set after a rising edge; outputs are checked at the falling
  // edge; the model advances on the next rising edge.
  task automatic cyc_check();
    @(negedge HCLK);
    model_check();
  endtask

  task automatic cyc_adv();
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  task automatic cyc();
    cyc_check();
    cyc_adv();
  endtask

  task automatic idle_inputs();
    HSELS = 0; HADDRS = '0; HTRANSS = HTRANS_IDLE; HWRITES = 0; HSIZES = 3'd2;
    HBURSTS = '0; HPROTS = 4'h3; HMASTLOCKS = 0; HREADYS = 1;
    HRESPM = HRESP_OKAY;
  endtask

  task automatic set_phase(input logic [1:0] tr, input logic [31:0] a,
                           input logic wr, input logic [2:0] bu);
    HSELS = 1; HREADYS = 1; HTRANSS = tr; HADDRS = a; HWRITES = wr; HBURSTS = bu;
    HSIZES = 3'd2; HPROTS = 4'h3; HMASTLOCKS = 0;
  endtask

  task automatic rand_inputs();
    HRESET     = ($urandom_range(0, 39) == 0);
    HSELS      = ($urandom_range(0, 3) != 0);
    HADDRS     = $urandom;
    HTRANSS    = 2'($urandom);
    HWRITES    = 1'($urandom);
    HSIZES     = 3'($urandom);
    HBURSTS    = 3'($urandom);
    HPROTS     = 4'($urandom);
    HMASTLOCKS = 1'($urandom);
    HREADYS    = ($urandom_range(0, 3) != 0);
    active_ob  = 1'($urandom);
    HREADYM    = ($urandom_range(0, 3) != 0);
    HRESPM     = ($urandom_range(0, 7) == 0) ? HRESP_ERROR : HRESP_OKAY;
  endtask

  initial begin
    idle_inputs();
    active_ob = 0; HREADYM = 1;
    HRESET = 1;
    #1;
    cyc(); cyc();
    HRESET = 0;

    cyc_check();
    chk_eq("rst_rdy",  64'(HREADYOUTS), 64'd1);
    chk_eq("rst_resp", 64'(HRESPS),     64'd0);
    chk_eq("rst_req",  64'(req_port),   64'd0);
    cyc_adv();

    // Granted single write.
    set_phase(HTRANS_NONSEQ, 32'h100, 1, 3'b000);
    active_ob = 1; HREADYM = 1;
    cyc_check();
    chk_eq("gw_addr", 64'(HADDRM), 64'h100);
    chk_eq("gw_req",  64'(req_port), 64'd1);
    cyc_adv();
    idle_inputs(); HREADYM = 0;
    cyc_check(); chk_eq("gw_wait_rdy", 64'(HREADYOUTS), 64'd0); cyc_adv();
    HREADYM = 1;
    cyc_check(); chk_eq("gw_done_rdy", 64'(HREADYOUTS), 64'd1); cyc_adv();

    // Not granted: held for three cycles, then granted.
    set_phase(HTRANS_NONSEQ, 32'h200, 0, 3'b000);
    active_ob = 0;
    cyc_check(); chk_eq("ng_req", 64'(req_port), 64'd1); cyc_adv();
    idle_inputs(); HREADYS = 0; HADDRS = 32'hDEAD0;
    for (int i = 0; i < 2; i++) begin
      cyc_check();
      chk_eq("ng_pend_rdy",  64'(HREADYOUTS), 64'd0);
      chk_eq("ng_pend_addr", 64'(HADDRM), 64'h200);
      chk_eq("ng_pend_req",  64'(req_port), 64'd1);
      cyc_adv();
    end
    active_ob = 1; HREADYM = 1;
    cyc_check(); chk_eq("ng_grant_addr", 64'(HADDRM), 64'h200); cyc_adv();
    HREADYS = 1;
    cyc_check(); chk_eq("ng_data_rdy", 64'(HREADYOUTS), 64'd1); cyc_adv();

    // Held SEQ replayed as NONSEQ/INCR.
    set_phase(HTRANS_SEQ, 32'h44, 0, 3'b011);
    active_ob = 0;
    cyc(); 
    idle_inputs(); HREADYS = 0;
    active_ob = 1; HREADYM = 1;
    cyc_check();
    chk_eq("seq_trans", 64'(HTRANSM), 64'(HTRANS_NONSEQ));
    chk_eq("seq_burst", 64'(HBURSTM), 64'(HBURST_INCR));
    chk_eq("seq_addr",  64'(HADDRM),  64'h44);
    cyc_adv();

    // Two-cycle ERROR response in the data phase.
    HREADYS = 1; HREADYM = 0; HRESPM = HRESP_ERROR;
    cyc_check();
    chk_eq("err1_resp", 64'(HRESPS), 64'd1);
    chk_eq("err1_rdy",  64'(HREADYOUTS), 64'd0);
    cyc_adv();
    HREADYM = 1;
    cyc_check();
    chk_eq("err2_resp", 64'(HRESPS), 64'd1);
    chk_eq("err2_rdy",  64'(HREADYOUTS), 64'd1);
    cyc_adv();
    HRESPM = HRESP_OKAY;

    // Grant lost at data completion.
    set_phase(HTRANS_NONSEQ, 32'h300, 1, 3'b000);
    active_ob = 1; HREADYM = 1;
    cyc();
    set_phase(HTRANS_NONSEQ, 32'h304, 1, 3'b000);
    active_ob = 0;
    cyc_check(); chk_eq("gl_done_rdy", 64'(HREADYOUTS), 64'd1); cyc_adv();
    idle_inputs(); HREADYS = 0;
    cyc_check();
    chk_eq("gl_pend_rdy",  64'(HREADYOUTS), 64'd0);
    chk_eq("gl_pend_addr", 64'(HADDRM), 64'h304);
    cyc_adv();

    // Reset while pending discards the held phase.
    HRESET = 1;
    cyc();
    HRESET = 0; idle_inputs(); active_ob = 1; HREADYM = 1;
    for (int i = 0; i < 2; i++) begin
      cyc_check();
      chk_eq("rp_rdy",   64'(HREADYOUTS), 64'd1);
      chk_eq("rp_req",   64'(req_port),   64'd0);
      chk_eq("rp_trans", 64'(HTRANSM),    64'(HTRANS_IDLE));
      cyc_adv();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
